// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//
// Architectural register file with two write ports, a parametrised number of
// combinational read ports, same-cycle write-to-read bypass, and a scoreboard
// holding one "write pending" bit per register. Register 0 is hardwired to
// zero and can never be written or marked busy.
//
// Parameters
//   DATA_WIDTH : register width in bits
//   ADDR_WIDTH : register index width, depth = 2**ADDR_WIDTH
//   NRD        : number of read ports (1..4)
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous active-low reset, clears data and busy bits
//   wen0/waddr0/wdata0 : write port 0 (ALU writeback)
//   wen1/waddr1/wdata1 : write port 1 (load return), wins over port 0
//   iss_valid/iss_rd   : issue marking iss_rd busy at the next edge
//   raddr      : packed read indices, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata      : packed read data, same packing, with write bypass
//   rbusy      : per-port "outstanding write not yet satisfied"
//   idle       : no registered busy bit is set
// -----------------------------------------------------------------------------
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NRD        = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wen0,
    input  logic [ADDR_WIDTH-1:0]      waddr0,
    input  logic [DATA_WIDTH-1:0]      wdata0,
    input  logic                       wen1,
    input  logic [ADDR_WIDTH-1:0]      waddr1,
    input  logic [DATA_WIDTH-1:0]      wdata1,
    input  logic                       iss_valid,
    input  logic [ADDR_WIDTH-1:0]      iss_rd,
    input  logic [NRD*ADDR_WIDTH-1:0]  raddr,
    output logic [NRD*DATA_WIDTH-1:0]  rdata,
    output logic [NRD-1:0]             rbusy,
    output logic                       idle
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = {ADDR_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_busy;
    logic [DEPTH-1:0]      w_busy_nxt;
    logic [ADDR_WIDTH-1:0] w_ra;

    // Register array: port 1 has priority when both ports hit the same entry;
    // entry 0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wen1 && (waddr1 == ADDR_WIDTH'(i))) begin
                    r_mem[i] <= wdata1;
                end else if (wen0 && (waddr0 == ADDR_WIDTH'(i))) begin
                    r_mem[i] <= wdata0;
                end
            end
        end
    end

    // Scoreboard next state: an issue beats a completing write to the same
    // index, because the write belongs to the older producer while the newly
    // issued one is still outstanding.
    always_comb begin
        w_busy_nxt = {DEPTH{1'b0}};
        for (int i = 1; i < DEPTH; i++) begin
            if (iss_valid && (iss_rd == ADDR_WIDTH'(i))) begin
                w_busy_nxt[i] = 1'b1;
            end else if ((wen0 && (waddr0 == ADDR_WIDTH'(i))) ||
                         (wen1 && (waddr1 == ADDR_WIDTH'(i)))) begin
                w_busy_nxt[i] = 1'b0;
            end else begin
                w_busy_nxt[i] = r_busy[i];
            end
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= {DEPTH{1'b0}};
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Read ports: bypass from the write ports (port 1 first), otherwise the
    // array. A same-cycle write to the read index satisfies the hazard, so it
    // also masks the busy bit. Outputs are forced quiet while reset is held.
    always_comb begin
        rdata = {(NRD*DATA_WIDTH){1'b0}};
        rbusy = {NRD{1'b0}};
        w_ra  = ZERO_IDX;
        for (int k = 0; k < NRD; k++) begin
            w_ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
            if (!rst || (w_ra == ZERO_IDX)) begin
                rdata[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
                rbusy[k] = 1'b0;
            end else if (wen1 && (waddr1 == w_ra)) begin
                rdata[k*DATA_WIDTH +: DATA_WIDTH] = wdata1;
                rbusy[k] = 1'b0;
            end else if (wen0 && (waddr0 == w_ra)) begin
                rdata[k*DATA_WIDTH +: DATA_WIDTH] = wdata0;
                rbusy[k] = 1'b0;
            end else begin
                rdata[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_ra];
                rbusy[k] = r_busy[w_ra];
            end
        end
    end

    // Idle looks only at registered busy bits, not at same-cycle activity.
    always_comb begin
        idle = ~(|r_busy);
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
//
// Directed self-checking bench for reg_file_sb (DATA_WIDTH=32, ADDR_WIDTH=5,
// NRD=2). Inputs change on the falling edge; outputs are checked 1 ns later,
// well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic        wen0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        wen1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        idle;

    int n_pass;
    int n_total;

    reg_file_sb #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .NRD(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wen0     (wen0),
        .waddr0   (waddr0),
        .wdata0   (wdata0),
        .wen1     (wen1),
        .waddr1   (waddr1),
        .wdata1   (wdata1),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .raddr    (raddr),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .idle     (idle)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        wen0 = 1'b0; waddr0 = 5'd0; wdata0 = 32'h0;
        wen1 = 1'b0; waddr1 = 5'd0; wdata1 = 32'h0;
        iss_valid = 1'b0; iss_rd = 5'd0;
    endtask

    task automatic set_raddr(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        idle_inputs();
        set_raddr(5'd3, 5'd3);

        // Reset release: write attempts to index 3 are ignored while held.
        wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hDEAD;
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst_rdata", rdata[31:0], 32'h0);
            chk("rst_rbusy", {31'h0, rbusy[0]}, 32'h0);
            chk("rst_idle", {31'h0, idle}, 32'h1);
        end
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("rel_rdata", rdata[31:0], 32'h0);
        @(negedge clk); #1;
        chk("rel_rdata2", rdata[31:0], 32'h0);
        chk("rel_idle", {31'h0, idle}, 32'h1);

        // Bypass priority: both ports write index 5, port 1 wins.
        @(negedge clk);
        wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h11;
        wen1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h22;
        set_raddr(5'd5, 5'd5);
        #1;
        chk("byp_p0", rdata[31:0], 32'h22);
        chk("byp_p1", rdata[63:32], 32'h22);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("byp_stored", rdata[31:0], 32'h22);

        // Different indices commit on both ports; port 0 alone also bypasses.
        @(negedge clk);
        wen0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'hAA;
        wen1 = 1'b1; waddr1 = 5'd11; wdata1 = 32'hBB;
        set_raddr(5'd10, 5'd11);
        #1;
        chk("dual_byp0", rdata[31:0], 32'hAA);
        chk("dual_byp1", rdata[63:32], 32'hBB);
        @(negedge clk);
        idle_inputs();
        wen0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h77;
        set_raddr(5'd12, 5'd11);
        #1;
        chk("p0_byp", rdata[31:0], 32'h77);
        chk("dual_st1", rdata[63:32], 32'hBB);
        @(negedge clk);
        idle_inputs();
        set_raddr(5'd10, 5'd12);
        #1;
        chk("dual_st0", rdata[31:0], 32'hAA);
        chk("p0_st", rdata[63:32], 32'h77);

        // Register zero: write and issue are dropped.
        @(negedge clk);
        wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
        iss_valid = 1'b1; iss_rd = 5'd0;
        set_raddr(5'd0, 5'd0);
        #1;
        chk("r0_rdata", rdata[31:0], 32'h0);
        chk("r0_rbusy", {31'h0, rbusy[0]}, 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("r0_rdata2", rdata[31:0], 32'h0);
        chk("r0_rbusy2", {31'h0, rbusy[0]}, 32'h0);
        chk("r0_idle", {31'h0, idle}, 32'h1);

        // Scoreboard lifecycle on index 7.
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd7;
        set_raddr(5'd7, 5'd0);
        #1;
        chk("sb_iss_rbusy", {31'h0, rbusy[0]}, 32'h0);
        chk("sb_iss_idle", {31'h0, idle}, 32'h1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("sb_busy_rbusy", {31'h0, rbusy[0]}, 32'h1);
        chk("sb_busy_idle", {31'h0, idle}, 32'h0);
        @(negedge clk);
        wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h55;
        #1;
        chk("sb_wr_rbusy", {31'h0, rbusy[0]}, 32'h0);
        chk("sb_wr_rdata", rdata[31:0], 32'h55);
        chk("sb_wr_idle", {31'h0, idle}, 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("sb_done_idle", {31'h0, idle}, 32'h1);
        chk("sb_done_rbusy", {31'h0, rbusy[0]}, 32'h0);
        chk("sb_done_rdata", rdata[31:0], 32'h55);

        // Set/clear collision on index 9: set wins.
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd9;
        set_raddr(5'd9, 5'd0);
        @(negedge clk);
        idle_inputs();
        wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hA;
        iss_valid = 1'b1; iss_rd = 5'd9;
        #1;
        chk("col_same_rbusy", {31'h0, rbusy[0]}, 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("col_rbusy", {31'h0, rbusy[0]}, 32'h1);
        chk("col_rdata", rdata[31:0], 32'hA);
        chk("col_idle", {31'h0, idle}, 32'h0);
        @(negedge clk);
        wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'hB;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("col_clr_idle", {31'h0, idle}, 32'h1);

        // Async reset mid-flight: registers 1..4 hold data and are busy.
        @(negedge clk);
        wen0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'h101;
        wen1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h102;
        @(negedge clk);
        wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h103;
        wen1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h104;
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk);
            idle_inputs();
            iss_valid = 1'b1; iss_rd = 5'(r);
        end
        @(negedge clk);
        idle_inputs();
        set_raddr(5'd1, 5'd4);
        #1;
        chk("mf_pre_rd1", rdata[31:0], 32'h101);
        chk("mf_pre_rd4", rdata[63:32], 32'h104);
        chk("mf_pre_busy", {30'h0, rbusy}, 32'h3);
        chk("mf_pre_idle", {31'h0, idle}, 32'h0);
        #1 rst = 1'b0;
        #1;
        chk("mf_rst_rd1", rdata[31:0], 32'h0);
        chk("mf_rst_rd4", rdata[63:32], 32'h0);
        chk("mf_rst_idle", {31'h0, idle}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("mf_post_rd1", rdata[31:0], 32'h0);
        chk("mf_post_busy", {30'h0, rbusy}, 32'h0);
        chk("mf_post_idle", {31'h0, idle}, 32'h1);
        @(negedge clk);
        wen0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'h33;
        set_raddr(5'd2, 5'd3);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("mf_wr_rdata", rdata[31:0], 32'h33);
        chk("mf_wr_rbusy", {31'h0, rbusy[0]}, 32'h0);
        chk("mf_r3_clear", rdata[63:32], 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-read-port register file with two write ports, same-cycle write-to-read bypass and a per-register scoreboard of pending writes. It replaces the single-write, two-read architectural register file in the RISC-V core. Decode uses it to read operands and detect RAW hazards. The ALU writeback and load-return paths write it independently.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- NRD, 2, number of read ports (1..4)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-low; clears all registers and busy bits
- wen0  in  1  write enable, port 0 (ALU writeback)
- waddr0  in  ADDR_WIDTH  write index, port 0
- wdata0  in  DATA_WIDTH  write data, port 0
- wen1  in  1  write enable, port 1 (load return)
- waddr1  in  ADDR_WIDTH  write index, port 1
- wdata1  in  DATA_WIDTH  write data, port 1
- iss_valid  in  1  an instruction issues with destination iss_rd
- iss_rd  in  ADDR_WIDTH  destination register to mark busy
- raddr  in  NRD*ADDR_WIDTH  read indices; port k is bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- rdata  out  NRD*DATA_WIDTH  read data, same packing
- rbusy  out  NRD  1 = port k's register has an outstanding write not yet satisfied
- idle  out  1  1 = no busy bits set

## Operation
- Storage: 2**ADDR_WIDTH entries. Register 0 is hardwired to zero.
  - Writes to index 0 are dropped.
  - Reads of index 0 return 0 with rbusy=0.
  - Issues to index 0 are dropped.
- Write, both ports enabled, same nonzero index: port 1 wins and port 0 is dropped. Different indices: both commit.
- Read port k, combinational:
  - rdata = wdata1 if wen1 and waddr1 == raddr_k != 0.
  - Else rdata = wdata0 if wen0 and waddr0 == raddr_k != 0.
  - Else rdata = the stored value, or 0 for index 0.
- Scoreboard: one busy bit per register; bit 0 is always 0.
  - Set: iss_valid with iss_rd != 0 sets busy[iss_rd] at the edge.
  - Clear: any enabled write to index a clears busy[a] at the edge.
  - Simultaneous set and clear of the same index: set wins. The older producer completes while the new producer is pending.
  - Issuing to an already-busy register keeps it busy; there is no counting.
- rbusy_k, combinational:
  - = busy[raddr_k] AND NOT a same-cycle write to raddr_k; the bypass satisfies the hazard.
  - A same-cycle issue does not raise rbusy; it is visible the next cycle.
- idle = NOR of all registered busy bits. It ignores same-cycle writes and issues.

## Timing
- Reset: rst low immediately clears all registers and busy bits (asynchronous).
  - Outputs follow: rdata=0, rbusy=0, idle=1.
  - While rst is low, writes and issues are ignored.
  - The first rising edge after rst rises performs normal updates.
- Reset mid-operation: pending busy bits are lost. The in-flight write that arrives later is an ordinary write to a non-busy register.
- Write latency: stored value visible on rdata in the same cycle via bypass, and from the array from the cycle after the edge.
- Issue latency: busy visible on rbusy and idle from the cycle after the edge.
- No handshake and no stall. Every enabled write and issue is accepted in its cycle.

## Test plan
- Reset release:
  - Stimulus: hold rst low with wen0=1, waddr0=3, wdata0=0xDEAD for 3 edges, then read index 3 after the wen0 pulse.
  - Required: rdata=0, rbusy=0, idle=1 throughout; index 3 reads 0 after release.
- Bypass priority:
  - Stimulus: in one cycle set wen0 with waddr0=5, wdata0=0x11 and wen1 with waddr1=5, wdata1=0x22; set raddr port0=5.
  - Required: same-cycle rdata=0x22; the next cycle reads 0x22.
- Register zero:
  - Stimulus: wen0 with waddr0=0, wdata0=0xFFFFFFFF, plus iss_valid with iss_rd=0; read index 0.
  - Required: rdata=0, rbusy=0, idle stays 1.
- Scoreboard lifecycle:
  - Stimulus: issue rd=7; in a later cycle, write wen1 with waddr1=7, wdata1=0x55.
  - Required cycle after issue: rbusy=1 for raddr=7, idle=0.
  - Required in the write cycle: rbusy=0 and rdata=0x55.
  - Required the cycle after the write: idle=1.
- Set and clear collision:
  - Stimulus: busy[9]=1; in one cycle, wen0 with waddr0=9, wdata0=0xA plus iss_valid with iss_rd=9.
  - Required next cycle: busy[9] remains 1, rbusy=1, rdata=0xA.
- Async reset mid-flight:
  - Stimulus: registers 1..4 busy with nonzero data; pulse rst low between edges.
  - Required: rdata=0 and idle=1 immediately; a later write to index 2 of 0x33 reads back 0x33 with rbusy=0.
